// File: rtl/i2c_rx_framer_if.sv
// Byte-stream-in / frame-word-out bundle for the I2C read-path framer.
// Latency: none (wiring only).
// Backpressure: only the output side (out_valid/out_ready); the byte side cannot stall.
interface i2c_rx_framer_if #(
    parameter int NBYTES = 4
);
    logic                  in_valid;
    logic [7:0]            in_data;
    logic                  in_last;
    logic                  in_nack;
    logic                  out_valid;
    logic                  out_ready;
    logic [8*NBYTES-1:0]   out_data;
    logic [2:0]            out_err;
    logic [15:0]           frame_cnt;
    logic [7:0]            drop_cnt;

    // Producer of bytes and consumer of frames (I2C master side + register logic)
    modport master (
        output in_valid, in_data, in_last, in_nack, out_ready,
        input  out_valid, out_data, out_err, frame_cnt, drop_cnt
    );

    // The framer itself
    modport slave (
        input  in_valid, in_data, in_last, in_nack, out_ready,
        output out_valid, out_data, out_err, frame_cnt, drop_cnt
    );
endinterface

// File: rtl/i2c_rx_framer.sv
// Packs NBYTES read bytes MSB-first into a word and classifies the frame end (ok/short/long/nack/timeout).
// Latency: frame status/data appear in the one-deep output buffer the cycle after the terminating byte/NACK.
// Backpressure: never stalls upstream; a termination with the buffer full and not draining is dropped and counted.
// Optional: define RX_TIMEOUT_EN to build the mid-frame idle watchdog (err 4 after TIMEOUT_CYCLES idle cycles).
module i2c_rx_framer #(
    parameter int NBYTES         = 4,
    parameter int TIMEOUT_CYCLES = 20000
) (
    input  logic            clk,
    input  logic            reset,
    i2c_rx_framer_if.slave  bus
);
    localparam int W  = 8 * NBYTES;
    localparam int IW = $clog2(NBYTES + 1);
    localparam logic [IW-1:0] NB    = IW'(NBYTES);
    localparam logic [IW-1:0] NB_M1 = IW'(NBYTES - 1);

    localparam logic [2:0] ERR_OK      = 3'd0;
    localparam logic [2:0] ERR_SHORT   = 3'd1;
    localparam logic [2:0] ERR_LONG    = 3'd2;
    localparam logic [2:0] ERR_NACK    = 3'd3;
    localparam logic [2:0] ERR_TIMEOUT = 3'd4;

    typedef enum logic [1:0] {IDLE, COLLECT, DISCARD} state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [W-1:0]    acc_q, acc_d;
    logic [W+7:0]    acc_shift;
    logic            term;
    logic [2:0]      term_err;
    logic [W-1:0]    term_dat;
    logic            timeout_hit;
    logic            load;

    // Accumulator with the incoming byte appended; the top byte falls off the wide vector
    assign acc_shift = {acc_q, bus.in_data};

`ifdef RX_TIMEOUT_EN
    localparam logic [31:0] TO_LIM = 32'(TIMEOUT_CYCLES - 1);
    logic [31:0] wdog_q;

    // Idle watchdog: counts cycles without a byte while a frame is open
    always_ff @(posedge clk) begin
        if (reset || state_q == IDLE || bus.in_valid || term)
            wdog_q <= '0;
        else
            wdog_q <= wdog_q + 32'd1;
    end

    // A byte or NACK in the expiry cycle takes precedence over the timeout
    assign timeout_hit = (state_q != IDLE) && !bus.in_valid && !bus.in_nack && (wdog_q == TO_LIM);
`else
    logic [31:0] unused_timeout;
    assign unused_timeout = 32'(TIMEOUT_CYCLES);
    assign timeout_hit    = 1'b0;
`endif

    // Frame state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            acc_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            acc_q   <= acc_d;
        end
    end

    // Next-state, byte packing and termination classification; NACK beats a same-cycle byte
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        acc_d    = acc_q;
        term     = 1'b0;
        term_err = ERR_OK;
        term_dat = '0;
        if (bus.in_nack) begin
            term     = 1'b1;
            term_err = ERR_NACK;
        end else if (bus.in_valid) begin
            if (state_q == DISCARD || idx_q == NB) begin
                // Byte beyond NBYTES: the frame is already too long
                if (bus.in_last) begin
                    term     = 1'b1;
                    term_err = ERR_LONG;
                end else begin
                    state_d = DISCARD;
                end
            end else if (bus.in_last) begin
                term = 1'b1;
                if (idx_q == NB_M1) begin
                    term_err = ERR_OK;
                    term_dat = acc_shift[W-1:0];
                end else begin
                    term_err = ERR_SHORT;
                end
            end else begin
                state_d = COLLECT;
                idx_d   = idx_q + 1'b1;
                acc_d   = acc_shift[W-1:0];
            end
        end else if (timeout_hit) begin
            term     = 1'b1;
            term_err = ERR_TIMEOUT;
        end
        if (term) begin
            state_d = IDLE;
            idx_d   = '0;
            acc_d   = '0;
        end
    end

    // Buffer accepts when empty or being drained this very cycle
    assign load = term && (!bus.out_valid || bus.out_ready);

    // One-deep output buffer with frame and drop counters
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
            bus.out_err   <= ERR_OK;
            bus.frame_cnt <= '0;
            bus.drop_cnt  <= '0;
        end else if (load) begin
            bus.out_valid <= 1'b1;
            bus.out_data  <= term_dat;
            bus.out_err   <= term_err;
            if (term_err == ERR_OK)
                bus.frame_cnt <= bus.frame_cnt + 16'd1;
        end else begin
            if (term && bus.drop_cnt != 8'hFF)
                bus.drop_cnt <= bus.drop_cnt + 8'd1;
            if (bus.out_valid && bus.out_ready)
                bus.out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_i2c_rx_framer.sv
// Self-checking bench for i2c_rx_framer: directed frames with literal expectations plus random traffic
// compared every cycle against a byte-count/queue level model of the frame rules.
// Define RX_TIMEOUT_EN for both bench and RTL to exercise the watchdog path.
module tb_i2c_rx_framer;
    localparam int NB = 4;
    localparam int TO = 100;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;
    bit   cmp_en  = 1'b0;
    bit   rand_ready = 1'b0;

    // Model state: bytes seen in the open transaction, packed word, idle time, expected buffer
    int           m_cnt  = 0;
    int           m_idle = 0;
    logic [63:0]  m_word = '0;
    bit           e_valid = 1'b0;
    logic [31:0]  e_data  = '0;
    logic [2:0]   e_err   = '0;
    logic [15:0]  e_fc    = '0;
    logic [7:0]   e_dc    = '0;

    i2c_rx_framer_if #(.NBYTES(NB)) bus ();

    i2c_rx_framer #(.NBYTES(NB), .TIMEOUT_CYCLES(TO)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: evaluated on each rising edge from the inputs the DUT samples there
    always @(posedge clk) begin : model
        bit       t;
        int       er;
        bit       drained;
        t = 1'b0;
        er = 0;
        if (reset) begin
            m_cnt = 0; m_idle = 0; m_word = '0;
            e_valid = 1'b0; e_data = '0; e_err = '0; e_fc = '0; e_dc = '0;
        end else begin
            if (bus.in_nack) begin
                t = 1'b1; er = 3;
            end else if (bus.in_valid) begin
                m_cnt++;
                m_idle = 0;
                if (m_cnt <= NB) m_word = (m_word << 8) | 64'(bus.in_data);
                if (bus.in_last) begin
                    t = 1'b1;
                    er = (m_cnt == NB) ? 0 : ((m_cnt < NB) ? 1 : 2);
                end
            end else if (m_cnt > 0) begin
`ifdef RX_TIMEOUT_EN
                m_idle++;
                if (m_idle == TO) begin t = 1'b1; er = 4; end
`endif
            end
            drained = e_valid && bus.out_ready;
            if (t) begin
                if (!e_valid || drained) begin
                    e_valid = 1'b1;
                    e_err   = 3'(er);
                    e_data  = (er == 0) ? m_word[31:0] : 32'd0;
                    if (er == 0) e_fc = e_fc + 16'd1;
                end else if (e_dc != 8'hFF) begin
                    e_dc = e_dc + 8'd1;
                end
                m_cnt = 0; m_idle = 0; m_word = '0;
            end else if (drained) begin
                e_valid = 1'b0;
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        if (cmp_en) begin
            check("cmp_valid", 64'(bus.out_valid), 64'(e_valid));
            if (e_valid) begin
                check("cmp_data", 64'(bus.out_data), 64'(e_data));
                check("cmp_err", 64'(bus.out_err), 64'(e_err));
            end
            check("cmp_frame_cnt", 64'(bus.frame_cnt), 64'(e_fc));
            check("cmp_drop_cnt", 64'(bus.drop_cnt), 64'(e_dc));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_ready) bus.out_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic send(input logic [7:0] d, input bit last, input bit nack);
        bus.in_valid = 1'b1; bus.in_data = d; bus.in_last = last; bus.in_nack = nack;
        tick();
        bus.in_valid = 1'b0; bus.in_last = 1'b0; bus.in_nack = 1'b0;
    endtask

    task automatic nack_only();
        bus.in_nack = 1'b1;
        tick();
        bus.in_nack = 1'b0;
    endtask

    task automatic send_frame(input logic [31:0] w);
        for (int i = 3; i >= 0; i--) send(w[8*i +: 8], i == 0, 1'b0);
    endtask

    initial begin : stim
        int lat;
        int len;
        int nack_at;
        bus.in_valid = 1'b0; bus.in_data = '0; bus.in_last = 1'b0; bus.in_nack = 1'b0;
        bus.out_ready = 1'b1;
        reset = 1'b1;
        idle(3);
        reset = 1'b0;
        cmp_en = 1'b1;
        idle(1);
        check("rst_valid", 64'(bus.out_valid), 64'd0);
        check("rst_data", 64'(bus.out_data), 64'd0);
        check("rst_err", 64'(bus.out_err), 64'd0);
        check("rst_frame_cnt", 64'(bus.frame_cnt), 64'd0);
        check("rst_drop_cnt", 64'(bus.drop_cnt), 64'd0);

        // Good frame
        send_frame(32'h12345678);
        check("ok_valid", 64'(bus.out_valid), 64'd1);
        check("ok_data", 64'(bus.out_data), 64'h12345678);
        check("ok_err", 64'(bus.out_err), 64'd0);
        check("ok_frame_cnt", 64'(bus.frame_cnt), 64'd1);
        idle(1);
        check("ok_drained", 64'(bus.out_valid), 64'd0);

        // Short frame
        send(8'hAA, 1'b0, 1'b0);
        send(8'hBB, 1'b1, 1'b0);
        check("short_err", 64'(bus.out_err), 64'd1);
        check("short_data", 64'(bus.out_data), 64'd0);
        check("short_frame_cnt", 64'(bus.frame_cnt), 64'd1);
        idle(1);

        // Long frame, then a good one packs cleanly
        for (int i = 0; i < 6; i++) begin
            send(8'hC0 + 8'(i), i == 5, 1'b0);
            if (i < 5) check("long_no_early_out", 64'(bus.out_valid), 64'd0);
        end
        check("long_err", 64'(bus.out_err), 64'd2);
        check("long_data", 64'(bus.out_data), 64'd0);
        idle(1);
        send_frame(32'h01020304);
        check("after_long_data", 64'(bus.out_data), 64'h01020304);
        check("after_long_frame_cnt", 64'(bus.frame_cnt), 64'd2);
        idle(1);

        // NACK with a byte, and NACK in idle
        send(8'h01, 1'b0, 1'b0);
        send(8'h02, 1'b0, 1'b0);
        send(8'h03, 1'b0, 1'b1);
        check("nack_err", 64'(bus.out_err), 64'd3);
        check("nack_data", 64'(bus.out_data), 64'd0);
        idle(1);
        nack_only();
        check("nack_idle_valid", 64'(bus.out_valid), 64'd1);
        check("nack_idle_err", 64'(bus.out_err), 64'd3);
        idle(1);
        check("nack_frame_cnt", 64'(bus.frame_cnt), 64'd2);

        // Backpressure: hold, drop, back-to-back reload
        bus.out_ready = 1'b0;
        send_frame(32'h11223344);
        check("bp_first_data", 64'(bus.out_data), 64'h11223344);
        idle(2);
        check("bp_hold_data", 64'(bus.out_data), 64'h11223344);
        send_frame(32'h55667788);
        check("bp_drop_data", 64'(bus.out_data), 64'h11223344);
        check("bp_drop_err", 64'(bus.out_err), 64'd0);
        check("bp_drop_cnt", 64'(bus.drop_cnt), 64'd1);
        check("bp_frame_cnt", 64'(bus.frame_cnt), 64'd3);
        send(8'h9A, 1'b0, 1'b0);
        send(8'hBC, 1'b0, 1'b0);
        send(8'hDE, 1'b0, 1'b0);
        bus.out_ready = 1'b1;
        send(8'hF0, 1'b1, 1'b0);
        check("b2b_valid", 64'(bus.out_valid), 64'd1);
        check("b2b_data", 64'(bus.out_data), 64'h9ABCDEF0);
        check("b2b_drop_cnt", 64'(bus.drop_cnt), 64'd1);
        check("b2b_frame_cnt", 64'(bus.frame_cnt), 64'd4);
        idle(2);

`ifdef RX_TIMEOUT_EN
        // Two bytes then silence: err 4 exactly TO cycles after the second byte
        send(8'hA1, 1'b0, 1'b0);
        send(8'hA2, 1'b0, 1'b0);
        lat = -1;
        for (int k = 1; k <= 3 * TO; k++) begin
            tick();
            if (bus.out_valid) begin
                lat = k;
                break;
            end
        end
        check("timeout_latency", 64'(lat), 64'(TO));
        check("timeout_err", 64'(bus.out_err), 64'd4);
        check("timeout_data", 64'(bus.out_data), 64'd0);
        idle(2);
`else
        // Without the watchdog a stalled frame simply waits and then completes
        send(8'hA1, 1'b0, 1'b0);
        send(8'hA2, 1'b0, 1'b0);
        idle(150);
        check("stall_no_output", 64'(bus.out_valid), 64'd0);
        send(8'hA3, 1'b0, 1'b0);
        send(8'hA4, 1'b1, 1'b0);
        check("stall_resume_data", 64'(bus.out_data), 64'hA1A2A3A4);
        idle(2);
`endif

        // Random traffic with random consumer readiness
        rand_ready = 1'b1;
        for (int t = 0; t < 300; t++) begin
            len = $urandom_range(0, 7);
            nack_at = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 7) : 99;
            if (len == 0) begin
                nack_only();
            end else begin
                for (int i = 0; i < len; i++) begin
                    if (i == nack_at) begin
                        send(8'($urandom), 1'b0, 1'b1);
                        break;
                    end
                    send(8'($urandom), i == len - 1, 1'b0);
                    idle($urandom_range(0, 2));
                end
            end
            idle($urandom_range(0, 3));
        end
        rand_ready = 1'b0;
        bus.out_ready = 1'b1;
        idle(3);

        // Reset mid-frame discards the partial frame and clears counters
        send(8'h01, 1'b0, 1'b0);
        send(8'h02, 1'b0, 1'b0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        idle(1);
        check("midrst_valid", 64'(bus.out_valid), 64'd0);
        check("midrst_frame_cnt", 64'(bus.frame_cnt), 64'd0);
        check("midrst_drop_cnt", 64'(bus.drop_cnt), 64'd0);
        send_frame(32'hDEADBEEF);
        check("postrst_data", 64'(bus.out_data), 64'hDEADBEEF);
        check("postrst_frame_cnt", 64'(bus.frame_cnt), 64'd1);
        idle(2);

        cmp_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/i2c_rx_framer.md
Name: i2c_rx_framer

Overview:
Downstream consumer of the I2C master's read path. Collects the byte stream produced during a read transaction, packs NBYTES bytes MSB-first into one word, and classifies how the frame ended (ok / short / long / NACK / timeout). Presents one status+data word through a one-deep valid/ready output buffer to the register/display logic. The I2C master cannot stall, so the block never back-pressures upstream and drops frames when the buffer is full.

Parameters:
NBYTES, 4, bytes per frame; legal range 1..8.
TIMEOUT_CYCLES, 20000, idle clk cycles mid-frame before abort; used only with RX_TIMEOUT_EN.

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
in_valid  input  1  one-cycle strobe: in_data holds a received byte
in_data  input  8  received byte, MSB of the frame first
in_last  input  1  qualifies in_valid: this byte is the final one of the transaction
in_nack  input  1  one-cycle strobe: master aborted the transaction (slave NACK)
out_valid  output  1  output buffer holds a frame
out_ready  input  1  consumer accepts the frame when out_valid && out_ready
out_data  output  8*NBYTES  packed frame; first byte in bits [8*NBYTES-1 -: 8]
out_err  output  3  0 ok, 1 short, 2 long, 3 nack, 4 timeout
frame_cnt  output  16  count of frames with out_err==0 loaded into the buffer; wraps
drop_cnt  output  8  count of dropped terminations; saturates at 255

Behaviour:
- Reset: out_valid=0, out_data=0, out_err=0, frame_cnt=0, drop_cnt=0, state IDLE, byte index=0, accumulator=0. Reset mid-frame discards the partial frame without producing output.
- FSM states: IDLE (no bytes yet), COLLECT (1..NBYTES-1 bytes held, or exactly NBYTES held while awaiting in_last), DISCARD (more than NBYTES bytes seen; waiting for the end of the transaction).
- Byte accept (in_valid): shift into the accumulator and increment the index. The index saturates at NBYTES; any further bytes move the FSM to DISCARD.
- Termination events:
  - in_last with exactly NBYTES bytes -> err 0.
  - in_last with fewer bytes -> err 1.
  - in_last in DISCARD, or the (NBYTES+1)th byte arriving with in_last -> err 2.
  - in_nack in any state, including IDLE -> err 3.
- Simultaneous in_valid and in_nack: NACK wins and the byte is ignored.
- After any termination: FSM returns to IDLE and the index and accumulator clear.
- Data field: out_data carries the packed word only for err 0; it is all zeros for every error code.
- Latency: termination on the cycle the last byte or NACK is sampled (cycle N); out_valid=1 and the fields are updated at cycle N+1.
- Output buffer load rules:
  - Loads if empty, or if out_valid && out_ready in the same cycle as the termination (back-to-back load, no bubble).
  - If full and not being drained: termination is dropped, drop_cnt increments, buffer contents are unchanged.
- Output hold: out_data and out_err are stable while out_valid && !out_ready; out_valid falls the cycle after the handshake unless reloaded.
- frame_cnt increments only when an err 0 frame is actually loaded; a dropped good frame does not count.
- New frame bytes may arrive the cycle after a termination.

Optional Feature:
RX_TIMEOUT_EN:
- Defined: a 32-bit watchdog clears on every accepted byte and runs while in COLLECT or DISCARD. On reaching TIMEOUT_CYCLES without in_valid or in_nack, the frame terminates with err 4 (same buffer and drop rules); FSM returns to IDLE. A byte arriving in the expiry cycle takes precedence and clears the watchdog.
- Not defined: no counter is built, err 4 is never produced, and a stalled frame waits indefinitely.

Test Plan:
- NBYTES=4, out_ready=1; bytes 0x12,0x34,0x56,0x78 (last on 0x78) -> one cycle later out_valid=1, out_data=0x12345678, out_err=0, frame_cnt=1.
- Bytes 0xAA,0xBB with last on 0xBB -> out_err=1, out_data=0; frame_cnt unchanged.
- Six bytes, last on the 6th -> single output with out_err=2; next good frame 0x01020304 is packed correctly.
- in_nack together with in_valid on the 3rd byte -> out_err=3, byte ignored; in_nack in IDLE -> out_err=3.
- out_ready=0, two good frames -> first held stable, second dropped, drop_cnt=1, frame_cnt=1; assert out_ready in the termination cycle of a third frame -> back-to-back load without drop.
- RX_TIMEOUT_EN, TIMEOUT_CYCLES=100; two bytes then silence -> err 4 exactly 100 cycles after the 2nd byte; reset asserted mid-frame -> no output, all counters 0.
